// File: rtl/cubehash_pkg.sv
// Shared types and sizes for the CubeHash core controller.
package cubehash_pkg;

    localparam int WORD_W    = 16;
    localparam int BLK_W     = 256;
    localparam int WORDS_DEF = BLK_W / WORD_W;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_WAIT,
        ST_FETCH,
        ST_OUT,
        ST_ERR
    } state_e;

    // Saturating step so a long stay in one state never wraps the counter.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/cubehash_ctrl.sv
// Sequences one 256-bit block into a 16-bit CubeHash core and reads the digest back; optional ack watchdog under CUBEHASH_CTRL_TIMEOUT_EN.
// Latency: single-block message reaches digest_valid 1 + WORDS + W + (WORDS+1) cycles after the accept edge (W = wait cycles incl. the ignored one).
// Backpressure: one block in flight; msg_ready only in IDLE, digest held stable until digest_ready.
module cubehash_ctrl
    import cubehash_pkg::*;
#(
    parameter int WORDS          = WORDS_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [WORDS*WORD_W-1:0] msg_data,
    input  logic                    msg_last,
    output logic                    digest_valid,
    input  logic                    digest_ready,
    output logic [WORDS*WORD_W-1:0] digest_data,
    output logic                    hash_error,
    output logic                    core_init,
    output logic                    core_load,
    output logic                    core_fetch,
    output logic [WORD_W-1:0]       core_idata,
    input  logic [WORD_W-1:0]       core_odata,
    input  logic                    core_ack
);

    localparam int                IDX_W     = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(WORDS);

    state_e                         state;
    state_e                         state_nxt;
    logic [CNT_W-1:0]               cnt;
    logic                           first_blk;
    logic                           last_reg;
    logic [WORDS-1:0][WORD_W-1:0]   msg_reg;
    logic [WORDS-1:0][WORD_W-1:0]   digest_reg;
    logic [IDX_W-1:0]               cap_idx;
    logic                           to_hit;

    // The core returns word k one cycle after fetch k, so capture lags the counter by one.
    assign cap_idx     = IDX_W'(cnt - 1'b1);
    assign digest_data = digest_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            first_blk <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_step(cnt);
            end
            if (state == ST_OUT && state_nxt == ST_IDLE) begin
                first_blk <= 1'b1;
            end else if (state_nxt == ST_LOAD && state != ST_LOAD) begin
                first_blk <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (msg_valid && msg_ready) begin
            msg_reg  <= msg_data;
            last_reg <= msg_last;
        end
        if (state == ST_FETCH && cnt != '0) begin
            digest_reg[cap_idx] <= core_odata;
        end
    end

    always_comb begin
        state_nxt    = state;
        msg_ready    = 1'b0;
        digest_valid = 1'b0;
        core_init    = 1'b0;
        core_load    = 1'b0;
        core_fetch   = 1'b0;
        core_idata   = '0;
        case (state)
            ST_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    state_nxt = first_blk ? ST_INIT : ST_LOAD;
                end
            end
            ST_INIT: begin
                core_init = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                core_load  = 1'b1;
                core_idata = msg_reg[cnt[IDX_W-1:0]];
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ack may still be high from the previous round on the first cycle
                if (cnt != '0 && core_ack) begin
                    state_nxt = last_reg ? ST_FETCH : ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_FETCH: begin
                core_fetch = (cnt < FETCH_END);
                if (cnt == FETCH_END) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (rst) begin
            msg_ready    = 1'b0;
            digest_valid = 1'b0;
            core_init    = 1'b0;
            core_load    = 1'b0;
            core_fetch   = 1'b0;
        end
    end

`ifdef CUBEHASH_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    assign to_hit     = (state == ST_WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign hash_error = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != ST_WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (state == ST_WAIT && state_nxt == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog the limit has no consumer.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_hit             = 1'b0;
    assign hash_error         = 1'b0;
`endif

endmodule
